sram_bist_master: RTL

- Command initiator for the SRAM controller. It drives the controller's write/read/address/data strobes itself instead of taking them from a bench or CPU.
- On `start`, it writes a deterministic pattern to every location, then reads each one back, compares it against the expected value, and reports the result.
- It sits between the system control logic and the SRAM controller. It is the built-in self-test / initialisation master for the memory.

---
 rtl/sram_bist_master.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sram_bist_master.sv
`default_nettype none
// ============================================================================
// Module : sram_bist_master
// Desc   : Writes a seeded address pattern to every SRAM location, reads each
//          one back and reports the mismatch count and first failing address.
// Rev    : 1.0  initial release
// ============================================================================
module sram_bist_master #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int HOLD   = 2,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pat_sel,
   input  logic [DATA_W-1:0] seed,
   output logic              mem_write,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   localparam int                  c_hold_w    = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam int                  c_lat_w     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [ADDR_W-1:0]   c_last_addr = '1;
   localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD - 1);
   localparam logic [c_lat_w-1:0]  c_lat_last  = c_lat_w'((RD_LAT > 0) ? RD_LAT - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR   = 3'd1,
      S_RD   = 3'd2,
      S_WAIT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t              r_state;
   logic [c_hold_w-1:0] r_hold;
   logic [c_lat_w-1:0]  r_lat;
   logic [DATA_W-1:0]   r_seed;
   logic                r_pat;

   logic                w_hold_last;
   logic                w_lat_last;
   logic                w_sample;
   logic                w_mismatch;
   logic [ADDR_W-1:0]   w_addr_inc;
   logic [ADDR_W:0]     w_err_next;
   logic [DATA_W-1:0]   w_expected;

   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] s,
                                                 input logic              inv);
      logic [DATA_W-1:0] v;
      v = DATA_W'(a) + s;
      return inv ? ~v : v;
   endfunction

   // mem_addr doubles as the walking address counter while the test runs
   assign w_hold_last = (r_hold == c_hold_last);
   assign w_lat_last  = (r_lat == c_lat_last);
   assign w_sample    = ((r_state == S_RD) && w_hold_last && (RD_LAT == 0)) ||
                        ((r_state == S_WAIT) && w_lat_last);
   assign w_expected  = pattern(mem_addr, r_seed, r_pat);
   assign w_mismatch  = w_sample && (mem_rdata != w_expected);
   assign w_addr_inc  = mem_addr + ADDR_W'(1);
   assign w_err_next  = err_count + {{ADDR_W{1'b0}}, w_mismatch};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_hold         <= '0;
         r_lat          <= '0;
         r_seed         <= '0;
         r_pat          <= 1'b0;
         mem_write      <= 1'b0;
         mem_read       <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         done <= 1'b0;
         if (w_mismatch) begin
            err_count <= w_err_next;
            if (err_count == '0)
               first_err_addr <= mem_addr;
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state        <= S_WR;
                  r_seed         <= seed;
                  r_pat          <= pat_sel;
                  r_hold         <= '0;
                  r_lat          <= '0;
                  busy           <= 1'b1;
                  pass           <= 1'b0;
                  err_count      <= '0;
                  first_err_addr <= '0;
                  mem_write      <= 1'b1;
                  mem_addr       <= '0;
                  mem_wdata      <= pattern('0, seed, pat_sel);
               end
            end
            S_WR: begin
               if (w_hold_last) begin
                  r_hold <= '0;
                  if (mem_addr == c_last_addr) begin
                     r_state   <= S_RD;
                     mem_write <= 1'b0;
                     mem_read  <= 1'b1;
                     mem_addr  <= '0;
                     mem_wdata <= '0;
                  end else begin
                     mem_addr  <= w_addr_inc;
                     mem_wdata <= pattern(w_addr_inc, r_seed, r_pat);
                  end
               end else begin
                  r_hold <= r_hold + c_hold_w'(1);
               end
            end
            S_RD: begin
               if (w_hold_last) begin
                  r_hold   <= '0;
                  mem_read <= 1'b0;
                  if (RD_LAT != 0)
                     r_state <= S_WAIT;
               end else begin
                  r_hold <= r_hold + c_hold_w'(1);
               end
            end
            S_WAIT: begin
               if (!w_lat_last)
                  r_lat <= r_lat + c_lat_w'(1);
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
         // Sample point overrides the per-state defaults above
         if (w_sample) begin
            r_lat <= '0;
            if (mem_addr == c_last_addr) begin
               r_state  <= S_DONE;
               busy     <= 1'b0;
               done     <= 1'b1;
               mem_addr <= '0;
               pass     <= (w_err_next == '0);
            end else begin
               r_state  <= S_RD;
               mem_read <= 1'b1;
               mem_addr <= w_addr_inc;
            end
         end
      end
   end

endmodule
`default_nettype wire
